// File: rtl/dest_ip_tbl_master.sv
`default_nettype none
// ============================================================================
//  Module   : dest_ip_tbl_master
//  Purpose  : Initiator side of the destination-IP table req/ack handshake.
//             Turns one register command into one single-cycle table request,
//             waits for the matching ack (or a timeout) and returns a response
//             while keeping completion and timeout statistics.
//  Revision : 1.0  initial release
// ============================================================================
module dest_ip_tbl_master #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TBL_ADDR_WIDTH     = 5,
   parameter int TIMEOUT_CYCLES     = 16,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                          AXI_ACLK,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_data,
   output logic                          rsp_err,
   output logic                          tbl_rd_req,
   output logic                          tbl_wr_req,
   output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
   output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
   input  logic                          tbl_rd_ack,
   input  logic                          tbl_wr_ack,
   output logic [CNT_WIDTH-1:0]          rd_done_count,
   output logic [CNT_WIDTH-1:0]          wr_done_count,
   output logic [CNT_WIDTH-1:0]          timeout_count
);

   // Last wait-counter value before the ack window closes (window <= 255).
   localparam logic [7:0]           C_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                          state_q,       state_d;
   logic [7:0]                      wait_cnt_q,    wait_cnt_d;
   logic                            is_wr_q,       is_wr_d;
   logic                            cmd_ready_q,   cmd_ready_d;
   logic                            rsp_valid_q,   rsp_valid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_data_q,    rsp_data_d;
   logic                            rsp_err_q,     rsp_err_d;
   logic                            rd_req_q,      rd_req_d;
   logic                            wr_req_q,      wr_req_d;
   logic [TBL_ADDR_WIDTH-1:0]       rd_addr_q,     rd_addr_d;
   logic [TBL_ADDR_WIDTH-1:0]       wr_addr_q,     wr_addr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data_q,     wr_data_d;
   logic [CNT_WIDTH-1:0]            rd_cnt_q,      rd_cnt_d;
   logic [CNT_WIDTH-1:0]            wr_cnt_q,      wr_cnt_d;
   logic [CNT_WIDTH-1:0]            tmo_cnt_q,     tmo_cnt_d;
   logic                            ack_hit;

   // Only the ack matching the captured command type is honoured.
   assign ack_hit = is_wr_q ? tbl_wr_ack : tbl_rd_ack;

   // Next-state and next-output computation for the handshake sequencer.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      is_wr_d     = is_wr_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rd_req_d    = 1'b0;           // requests are single-cycle pulses
      wr_req_d    = 1'b0;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               is_wr_d     = cmd_write;
               if (cmd_write) begin
                  wr_req_d  = 1'b1;
                  wr_addr_d = cmd_addr;
                  wr_data_d = cmd_wdata;
               end else begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = cmd_addr;
               end
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            wait_cnt_d = 8'd0;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            if (ack_hit) begin
               rsp_data_d  = is_wr_q ? '0 : tbl_rd_data;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               if (is_wr_q) wr_cnt_d = wr_cnt_q + C_CNT_ONE;
               else         rd_cnt_d = rd_cnt_q + C_CNT_ONE;
               state_d     = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q == C_WAIT_LAST) begin
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  tmo_cnt_d   = tmo_cnt_q + C_CNT_ONE;
                  state_d     = S_RESP;
               end
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset clears everything, including mid-wait.
   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 8'd0;
         is_wr_q     <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rd_req_q    <= 1'b0;
         wr_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         is_wr_q     <= is_wr_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rd_req_q    <= rd_req_d;
         wr_req_q    <= wr_req_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign tbl_rd_req    = rd_req_q;
   assign tbl_wr_req    = wr_req_q;
   assign tbl_rd_addr   = rd_addr_q;
   assign tbl_wr_addr   = wr_addr_q;
   assign tbl_wr_data   = wr_data_q;
   assign rd_done_count = rd_cnt_q;
   assign wr_done_count = wr_cnt_q;
   assign timeout_count = tmo_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dest_ip_tbl_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dest_ip_tbl_master
//  Purpose  : Directed self-checking bench for dest_ip_tbl_master with a
//             table responder model (1-cycle ack) and manual ack injection.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dest_ip_tbl_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic        tbl_rd_req, tbl_wr_req;
   logic [4:0]  tbl_rd_addr, tbl_wr_addr;
   logic [31:0] tbl_wr_data, tbl_rd_data;
   logic        tbl_rd_ack, tbl_wr_ack;
   logic [31:0] rd_done_count, wr_done_count, timeout_count;

   // Responder selection: model (auto_en=1) or manual injection.
   logic        auto_en;
   logic        m_rd_ack, m_wr_ack;
   logic [31:0] m_rd_data;
   logic        man_rd_ack, man_wr_ack;
   logic [31:0] man_rd_data;

   assign tbl_rd_ack  = auto_en ? m_rd_ack  : man_rd_ack;
   assign tbl_wr_ack  = auto_en ? m_wr_ack  : man_wr_ack;
   assign tbl_rd_data = auto_en ? m_rd_data : man_rd_data;

   int checks = 0;
   int passed = 0;

   dest_ip_tbl_master dut (
      .AXI_ACLK      (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .tbl_rd_req    (tbl_rd_req),
      .tbl_wr_req    (tbl_wr_req),
      .tbl_rd_addr   (tbl_rd_addr),
      .tbl_wr_addr   (tbl_wr_addr),
      .tbl_wr_data   (tbl_wr_data),
      .tbl_rd_data   (tbl_rd_data),
      .tbl_rd_ack    (tbl_rd_ack),
      .tbl_wr_ack    (tbl_wr_ack),
      .rd_done_count (rd_done_count),
      .wr_done_count (wr_done_count),
      .timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder model: table memory, ack one cycle after each request cycle,
   // plus pulse bookkeeping (pulse count and over-long request detection).
   logic [31:0] mem [32];
   logic        prev_rd = 1'b0, prev_wr = 1'b0;
   logic [4:0]  prev_raddr = '0;
   logic [4:0]  last_wr_addr = '0;
   int          rd_run = 0, wr_run = 0;
   int          rd_pulses = 0, wr_pulses = 0, long_reqs = 0;

   always @(posedge clk) begin
      #1;
      m_rd_ack  = prev_rd;
      m_wr_ack  = prev_wr;
      m_rd_data = prev_rd ? mem[prev_raddr] : 32'd0;
      prev_rd   = tbl_rd_req;
      prev_wr   = tbl_wr_req;
      if (tbl_rd_req) prev_raddr = tbl_rd_addr;
      if (tbl_wr_req) begin
         mem[tbl_wr_addr] = tbl_wr_data;
         last_wr_addr     = tbl_wr_addr;
      end
      rd_run = tbl_rd_req ? rd_run + 1 : 0;
      wr_run = tbl_wr_req ? wr_run + 1 : 0;
      if (rd_run == 1) rd_pulses++;
      if (wr_run == 1) wr_pulses++;
      if (rd_run == 2 || wr_run == 2) long_reqs++;
   end

   // Advance to the sample/drive point one unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, wait (bounded) for the response and consume it.
   // lat is the cycle of rsp_valid counted from the accept cycle (=0), -1 on hang.
   task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic err, output int lat);
      int guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin step(); guard++; end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      step();
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
      rdata = rsp_data;
      err   = rsp_err;
      if (rsp_valid !== 1'b1) lat = -1;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++;
      if ({cmd_ready, rsp_valid, rsp_err, tbl_rd_req, tbl_wr_req} !== 5'b0)
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {cmd_ready, rsp_valid, rsp_err, tbl_rd_req, tbl_wr_req});
      else passed++;
      checks++;
      if ({rsp_data, tbl_rd_addr, tbl_wr_addr, tbl_wr_data} !== 74'd0)
         $display("FAIL reset_data: rsp_data=%h rd_addr=%0d wr_addr=%0d wr_data=%h expected all 0",
                  rsp_data, tbl_rd_addr, tbl_wr_addr, tbl_wr_data);
      else passed++;
      checks++;
      if ({rd_done_count, wr_done_count, timeout_count} !== 96'd0)
         $display("FAIL reset_counters: rd=%0d wr=%0d tmo=%0d expected 0",
                  rd_done_count, wr_done_count, timeout_count);
      else passed++;
      reset = 1'b0;
      step();
      checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready);
      else passed++;
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic err; int lat; int wp0, lr0;
      auto_en = 1'b1;
      wp0 = wr_pulses; lr0 = long_reqs;
      do_cmd(1'b1, 5'd5, 32'hC0A80001, rd, err, lat);
      checks++;
      if (lat !== 3 || err !== 1'b0 || rd !== 32'd0)
         $display("FAIL wr_resp: lat=%0d err=%b data=%h expected 3/0/0", lat, err, rd);
      else passed++;
      checks++;
      if (wr_pulses - wp0 !== 1 || long_reqs !== lr0 || last_wr_addr !== 5'd5)
         $display("FAIL wr_pulse: pulses=%0d long=%0d addr=%0d expected 1/0/5",
                  wr_pulses - wp0, long_reqs - lr0, last_wr_addr);
      else passed++;
      do_cmd(1'b0, 5'd5, 32'd0, rd, err, lat);
      checks++;
      if (lat !== 3 || err !== 1'b0 || rd !== 32'hC0A80001)
         $display("FAIL rd_resp: lat=%0d err=%b data=%h expected 3/0/c0a80001", lat, err, rd);
      else passed++;
      checks++;
      if (wr_done_count !== 32'd1 || rd_done_count !== 32'd1)
         $display("FAIL wr_rd_counts: wr=%0d rd=%0d expected 1/1", wr_done_count, rd_done_count);
      else passed++;
   endtask

   task automatic test_timeout();
      logic [31:0] rd; logic err; int lat;
      auto_en = 1'b0;
      do_cmd(1'b0, 5'd31, 32'd0, rd, err, lat);   // ends in cycle 19
      checks++;
      if (lat !== 18 || err !== 1'b1 || rd !== 32'd0)
         $display("FAIL timeout_resp: lat=%0d err=%b data=%h expected 18/1/0", lat, err, rd);
      else passed++;
      step();                                      // cycle 20: late ack
      man_rd_ack = 1'b1; man_rd_data = 32'hBADBAD00;
      step();
      man_rd_ack = 1'b0; man_rd_data = 32'd0;
      step();
      checks++;
      if (timeout_count !== 32'd1 || rd_done_count !== 32'd1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0)
         $display("FAIL late_ack: tmo=%0d rd=%0d valid=%b data=%h expected 1/1/0/0",
                  timeout_count, rd_done_count, rsp_valid, rsp_data);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic err; int lat; int bad;
      auto_en = 1'b1;
      do_cmd(1'b1, 5'd7, 32'hDEADBEEF, rd, err, lat);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd7;
      step();
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
      checks++;
      if (lat !== 3) $display("FAIL bp_latency: got %0d expected 3", lat);
      else passed++;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0 || cmd_ready !== 1'b0)
            bad++;
         step();
      end
      checks++;
      if (bad !== 0 || rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF)
         $display("FAIL bp_stable: unstable cycles=%0d valid=%b data=%h expected 0/1/deadbeef",
                  bad, rsp_valid, rsp_data);
      else passed++;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL bp_release: ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
      else passed++;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd8; cmd_wdata = 32'h00000055;
      step();
      cmd_valid = 1'b0;
      checks++;
      if (tbl_wr_req !== 1'b1 || tbl_wr_addr !== 5'd8 || cmd_ready !== 1'b0)
         $display("FAIL bp_next_accept: wr_req=%b addr=%0d ready=%b expected 1/8/0",
                  tbl_wr_req, tbl_wr_addr, cmd_ready);
      else passed++;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_wrong_ack();
      auto_en = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3;
      step();                                      // cycle 1: REQ
      cmd_valid = 1'b0;
      checks++;
      if (tbl_rd_req !== 1'b1 || tbl_wr_req !== 1'b0 || tbl_rd_addr !== 5'd3)
         $display("FAIL rd_req_pulse: rd=%b wr=%b addr=%0d expected 1/0/3",
                  tbl_rd_req, tbl_wr_req, tbl_rd_addr);
      else passed++;
      step();                                      // cycle 2: WAIT
      man_wr_ack = 1'b1;
      step();
      man_wr_ack = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL wrong_ack: rsp_valid=%b expected 0", rsp_valid);
      else passed++;
      man_rd_ack = 1'b1; man_rd_data = 32'h12345678;
      step();
      man_rd_ack = 1'b0; man_rd_data = 32'd0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_err !== 1'b0)
         $display("FAIL right_ack: valid=%b data=%h err=%b expected 1/12345678/0",
                  rsp_valid, rsp_data, rsp_err);
      else passed++;
      checks++;
      if (rd_done_count !== 32'd3 || wr_done_count !== 32'd3)
         $display("FAIL ack_counts: rd=%0d wr=%0d expected 3/3", rd_done_count, wr_done_count);
      else passed++;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      auto_en = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd2;
      step();
      cmd_valid = 1'b0;
      step(); step();                              // in WAIT
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({cmd_ready, rsp_valid, rsp_err, tbl_rd_req, tbl_wr_req, rsp_data, tbl_rd_addr} !== 42'd0)
         $display("FAIL midwait_reset_outs: ready=%b valid=%b err=%b data=%h rd_addr=%0d expected 0",
                  cmd_ready, rsp_valid, rsp_err, rsp_data, tbl_rd_addr);
      else passed++;
      checks++;
      if ({rd_done_count, wr_done_count, timeout_count} !== 96'd0)
         $display("FAIL midwait_reset_cnts: rd=%0d wr=%0d tmo=%0d expected 0",
                  rd_done_count, wr_done_count, timeout_count);
      else passed++;
      step();
      checks++;
      if (cmd_ready !== 1'b1) $display("FAIL midwait_idle: cmd_ready=%b expected 1", cmd_ready);
      else passed++;
      man_rd_ack = 1'b1; man_rd_data = 32'h0000AAAA;
      step();
      man_rd_ack = 1'b0; man_rd_data = 32'd0;
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rd_done_count !== 32'd0)
         $display("FAIL post_reset_ack: valid=%b data=%h rd=%0d expected 0/0/0",
                  rsp_valid, rsp_data, rd_done_count);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic err; int lat; int rp0, wp0, lr0;
      auto_en = 1'b1;
      rp0 = rd_pulses; wp0 = wr_pulses; lr0 = long_reqs;
      for (int i = 0; i < 32; i++) begin
         do_cmd(1'b1, 5'(i), 32'(i * 3), rd, err, lat);
         checks++;
         if (lat !== 3 || err !== 1'b0)
            $display("FAIL b2b_wr[%0d]: lat=%0d err=%b expected 3/0", i, lat, err);
         else passed++;
      end
      for (int i = 0; i < 32; i++) begin
         do_cmd(1'b0, 5'(i), 32'd0, rd, err, lat);
         checks++;
         if (rd !== 32'(i * 3) || err !== 1'b0 || lat !== 3)
            $display("FAIL b2b_rd[%0d]: data=%h err=%b lat=%0d expected %h/0/3",
                     i, rd, err, lat, 32'(i * 3));
         else passed++;
      end
      checks++;
      if (wr_done_count !== 32'd32 || rd_done_count !== 32'd32)
         $display("FAIL b2b_counts: wr=%0d rd=%0d expected 32/32", wr_done_count, rd_done_count);
      else passed++;
      checks++;
      if (wr_pulses - wp0 !== 32 || rd_pulses - rp0 !== 32 || long_reqs !== lr0)
         $display("FAIL b2b_pulses: wr=%0d rd=%0d long=%0d expected 32/32/0",
                  wr_pulses - wp0, rd_pulses - rp0, long_reqs - lr0);
      else passed++;
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      auto_en = 1'b1;
      man_rd_ack = 1'b0; man_wr_ack = 1'b0; man_rd_data = '0;
      test_reset();
      test_write_read();
      test_timeout();
      test_backpressure();
      test_wrong_ack();
      test_reset_mid_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dest_ip_tbl_master.md
Name: dest_ip_tbl_master

Overview:
Initiator side of the destination-IP table access handshake: req/ack, 5-bit address, 32-bit data. It takes single register commands (read or write) from the register/AXI-Lite decode block and turns each into exactly one single-cycle tbl_rd_req or tbl_wr_req pulse toward the table responder. It then waits for the matching ack and returns read data or a timeout error, and keeps completion and timeout statistics for software.

Parameters:
C_S_AXI_DATA_WIDTH, 32, table entry / data width
TBL_ADDR_WIDTH, 5, table address width (32 entries)
TIMEOUT_CYCLES, 16, ack window in cycles after the req cycle; legal range 1..255
CNT_WIDTH, 32, width of statistics counters

Ports:
AXI_ACLK  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  TBL_ADDR_WIDTH  table index
cmd_wdata  in  C_S_AXI_DATA_WIDTH  write value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_data  out  C_S_AXI_DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  1=timeout
tbl_rd_req  out  1  read request pulse
tbl_wr_req  out  1  write request pulse
tbl_rd_addr  out  TBL_ADDR_WIDTH  read index
tbl_wr_addr  out  TBL_ADDR_WIDTH  write index
tbl_wr_data  out  C_S_AXI_DATA_WIDTH  write value
tbl_rd_data  in  C_S_AXI_DATA_WIDTH  responder read data; valid with tbl_rd_ack
tbl_rd_ack  in  1  read ack
tbl_wr_ack  in  1  write ack
rd_done_count  out  CNT_WIDTH  reads completed with ack
wr_done_count  out  CNT_WIDTH  writes completed with ack
timeout_count  out  CNT_WIDTH  commands ended by timeout

Behaviour:
- Reset: every output is 0. State is IDLE, the wait counter is 0 and all statistics counters are 0. Reset overrides everything in any state, including mid-WAIT. An ack arriving after such a reset is ignored.
- States: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE: cmd_ready=1. On accept, capture write flag, addr and wdata, then go to REQ.
- REQ (exactly one cycle):
  - Write: tbl_wr_req=1, tbl_wr_addr/tbl_wr_data driven.
  - Read: tbl_rd_req=1, tbl_rd_addr driven.
  - The other req stays 0. Go to WAIT with wait counter=0.
- Requests are never held more than one cycle, because the responder performs one write or read per asserted cycle. Addr and data hold their values until the next accept.
- WAIT: monitor only the ack matching the captured type; the opposite ack is ignored.
  - Matching ack seen: read captures tbl_rd_data into rsp_data; write sets rsp_data=0. rsp_err=0. Increment the matching done counter, then go to RESP.
  - No ack: increment the wait counter. When the counter reaches TIMEOUT_CYCLES with no ack, set rsp_err=1 and rsp_data=0, increment timeout_count, then go to RESP.
- Timing: accept at cycle 0, req at cycle 1, ack window is cycles 2..1+TIMEOUT_CYCLES.
  - Ack in cycle k gives rsp_valid from cycle k+1. With a responder that acks the next cycle, rsp_valid is at cycle 3.
  - Timeout gives rsp_valid from cycle 2+TIMEOUT_CYCLES.
- RESP: rsp_valid=1 and rsp_data/rsp_err are stable until rsp_ready. On handshake, clear rsp_valid and go to IDLE, so cmd_ready=1 the next cycle. Minimum command-to-command spacing is 4 cycles.
- Acks in IDLE, REQ or RESP (stale or late after timeout) are ignored and never change rsp_data or counters.
- Counters wrap modulo 2^CNT_WIDTH; no saturation.
- cmd_ready=0 in REQ, WAIT and RESP. Only one command is outstanding at a time.

Test Plan:
1. Responder model with 1-cycle ack. Write addr 5 = 0xC0A80001, then read addr 5 -> tbl_wr_req high exactly 1 cycle with addr 5. Read rsp_data=0xC0A80001, rsp_err=0, rsp_valid at cycle 3 after accept. wr_done_count=1, rd_done_count=1.
2. Acks tied low, read addr 31 -> rsp_valid with rsp_err=1, rsp_data=0 at cycle 18 (TIMEOUT_CYCLES=16). timeout_count=1. An ack injected at cycle 20 is ignored.
3. rsp_ready held low 10 cycles after a read of 0xDEADBEEF -> rsp_valid and rsp_data stay stable 10 cycles. cmd_ready=0 throughout. Next command accepted the cycle after the handshake.
4. During a read WAIT, inject tbl_wr_ack only -> ignored. Then a tbl_rd_ack with 0x12345678 -> rsp_data=0x12345678 and rd_done_count increments, wr_done_count does not.
5. Assert reset while in WAIT -> next cycle all outputs and counters are 0, state IDLE, cmd_ready=1. A subsequent ack has no effect.
6. 32 back-to-back writes (addr i, data i*3) then 32 reads with rsp_ready=1 -> each read returns i*3, and each req is exactly one cycle. wr_done_count=32, rd_done_count=32.
